// File: rtl/mapa_matrix_scan_if.sv
// Bundle of the map-word load port and the matrix pin outputs of mapa_matrix_scan.
// The master side feeds map words in; the slave side drives the physical matrix.
`timescale 1ns/1ps
interface mapa_matrix_scan_if #(
  parameter int N_COLS = 5,
  parameter int N_ROWS = 7
);
  logic [N_COLS*N_ROWS-1:0] PAT;
  logic                     LD;
  logic [1:0]               MODE;
  logic [N_COLS-1:0]        COL;
  logic [N_ROWS-1:0]        ROW;
  logic                     BUSY;
  logic                     FRAME;

  modport master (output PAT, LD, MODE, input COL, ROW, BUSY, FRAME);
  modport slave  (input PAT, LD, MODE, output COL, ROW, BUSY, FRAME);
endinterface

// File: rtl/mapa_matrix_scan.sv
// Column-multiplexed LED matrix driver: a shadow map word is swapped into the active word only
// at frame wraps, and one column at a time is scanned with leading dead-time blanking.
`timescale 1ns/1ps
module mapa_matrix_scan #(
  parameter int N_COLS       = 5,
  parameter int N_ROWS       = 7,
  parameter int DIV          = 1000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mapa_matrix_scan_if.slave   bus
);
  localparam int W  = N_COLS * N_ROWS;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_COLS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      active_q, active_d;
  logic [W-1:0]      shadow_q, shadow_d;
  logic              busy_q, busy_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic [N_COLS-1:0] col_q, col_d;
  logic [N_ROWS-1:0] row_q, row_d;
  logic              frame_q, frame_d;

  logic              cnt_wrap_s;
  logic              frame_wrap_s;
  logic [N_ROWS-1:0] col_bits_s;
  mode_e             mode_s;

  // Next-state for the scan position, buffers, blink phase and the registered pin values.
  always_comb begin
    mode_s       = mode_e'(bus.MODE);
    cnt_wrap_s   = (cnt_q == CNT_LAST);
    frame_wrap_s = cnt_wrap_s && (idx_q == IDX_LAST);

    cnt_d = cnt_wrap_s ? {CW{1'b0}} : (cnt_q + CW'(1));

    if (frame_wrap_s) begin
      idx_d = {IW{1'b0}};
    end else if (cnt_wrap_s) begin
      idx_d = idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end

    // The swap consumes the word already in the shadow, so a load on the same edge stays pending.
    active_d = active_q;
    busy_d   = busy_q;
    if (frame_wrap_s && busy_q) begin
      active_d = shadow_q;
      busy_d   = 1'b0;
    end else begin
      active_d = active_q;
    end
    if (bus.LD) begin
      shadow_d = bus.PAT;
      busy_d   = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_wrap_s) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = {FW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d = fcnt_q;
    end

    col_bits_s = {N_ROWS{1'b0}};
    for (int c = 0; c < N_COLS; c++) begin
      col_bits_s = (idx_q == IW'(c)) ? active_q[c*N_ROWS +: N_ROWS] : col_bits_s;
    end

    if ((cnt_q < BLANK_END) || (mode_s == MODE_OFF)) begin
      col_d = {N_COLS{1'b0}};
      row_d = {N_ROWS{1'b0}};
    end else begin
      col_d = {{(N_COLS-1){1'b0}}, 1'b1} << idx_q;
      case (mode_s)
        MODE_NORMAL: row_d = col_bits_s;
        MODE_INVERT: row_d = ~col_bits_s;
        MODE_BLINK:  row_d = phase_q ? {N_ROWS{1'b0}} : col_bits_s;
        default:     row_d = {N_ROWS{1'b0}};
      endcase
    end

    frame_d = frame_wrap_s;
  end

  // State and output registers; reset clears the pins immediately and drops any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CW{1'b0}};
      idx_q    <= {IW{1'b0}};
      active_q <= {W{1'b0}};
      shadow_q <= {W{1'b0}};
      busy_q   <= 1'b0;
      fcnt_q   <= {FW{1'b0}};
      phase_q  <= 1'b0;
      col_q    <= {N_COLS{1'b0}};
      row_q    <= {N_ROWS{1'b0}};
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      col_q    <= col_d;
      row_q    <= row_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.COL   = col_q;
  assign bus.ROW   = row_q;
  assign bus.BUSY  = busy_q;
  assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_mapa_matrix_scan.sv
// Bench for mapa_matrix_scan (5x7, DIV=4, BLANK=1, BLINK_FRAMES=2): per-cycle scoreboard driven
// by a time-based reference model, plus a vector table and hand-written load/reset sequences.
`timescale 1ns/1ps
module tb_mapa_matrix_scan;
  localparam int NC = 5;
  localparam int NR = 7;
  localparam int DIV_T = 4;
  localparam int BLANK_T = 1;
  localparam int BF_T = 2;
  localparam int FRAME_LEN = NC * DIV_T;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mapa_matrix_scan_if #(.N_COLS(NC), .N_ROWS(NR)) bus ();

  mapa_matrix_scan #(
    .N_COLS(NC), .N_ROWS(NR), .DIV(DIV_T), .BLANK(BLANK_T), .BLINK_FRAMES(BF_T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position inside the scan derives from cycles since reset.
  int          m_t;
  logic [34:0] m_active;
  logic [34:0] m_shadow;
  logic        m_busy;
  logic [13:0] exp_q[$];

  typedef struct {
    logic        ld;
    logic [34:0] pat;
    logic [1:0]  mode;
    int          cycles;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, m_t, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_active = '0;
    m_shadow = '0;
    m_busy   = 1'b0;
    exp_q.delete();
  endtask

  task automatic tick(input logic ld, input logic [34:0] pat, input logic [1:0] mode);
    int          pos;
    int          cnt;
    int          idx;
    int          ph;
    logic [6:0]  b;
    logic [4:0]  ec;
    logic [6:0]  er;
    logic        ef;
    logic [13:0] got_v;
    logic [13:0] exp_v;
    bus.LD   = ld;
    bus.PAT  = pat;
    bus.MODE = mode;
    pos = m_t % FRAME_LEN;
    cnt = pos % DIV_T;
    idx = pos / DIV_T;
    ph  = ((m_t / FRAME_LEN) / BF_T) % 2;
    b   = 7'(m_active >> (idx * NR));
    if (cnt < BLANK_T || mode == 2'b11) begin
      ec = 5'b00000;
      er = 7'h00;
    end else begin
      ec = 5'b00001 << idx;
      case (mode)
        2'b00:   er = b;
        2'b01:   er = ~b;
        default: er = (ph == 0) ? b : 7'h00;
      endcase
    end
    ef = (pos == FRAME_LEN - 1);
    if (pos == FRAME_LEN - 1 && m_busy) begin
      m_active = m_shadow;
      m_busy   = 1'b0;
    end
    if (ld) begin
      m_shadow = pat;
      m_busy   = 1'b1;
    end
    m_t++;
    exp_q.push_back({ec, er, m_busy, ef});
    @(posedge clk);
    @(negedge clk);
    got_v = {bus.COL, bus.ROW, bus.BUSY, bus.FRAME};
    exp_v = exp_q.pop_front();
    check("scan", got_v, exp_v);
  endtask

  task automatic run(input int n, input logic [1:0] mode);
    for (int i = 0; i < n; i++) tick(1'b0, 35'h0, mode);
  endtask

  task automatic run_to_pos(input int p, input logic [1:0] mode);
    for (int i = 0; i < FRAME_LEN && (m_t % FRAME_LEN) != p; i++) tick(1'b0, 35'h0, mode);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.LD   = 1'b0;
    bus.PAT  = 35'h0;
    bus.MODE = 2'b00;

    vecs[0] = '{1'b0, 35'h0,  2'b00, 45,  1'b0};
    vecs[1] = '{1'b1, 35'h55, 2'b00, 50,  1'b1};
    vecs[2] = '{1'b1, 35'h1,  2'b00, 3,   1'b1};
    vecs[3] = '{1'b1, 35'h2,  2'b00, 40,  1'b1};
    vecs[4] = '{1'b1, 35'h55, 2'b00, 45,  1'b1};
    vecs[5] = '{1'b0, 35'h0,  2'b01, 40,  1'b0};
    vecs[6] = '{1'b0, 35'h0,  2'b10, 100, 1'b0};
    vecs[7] = '{1'b0, 35'h0,  2'b11, 30,  1'b0};
    vecs[8] = '{1'b0, 35'h0,  2'b00, 10,  1'b0};

    @(negedge clk);
    @(negedge clk);
    check("reset_state", {bus.COL, bus.ROW, bus.BUSY, bus.FRAME}, 14'h0);
    model_reset();
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      tick(vecs[v].ld, vecs[v].pat, vecs[v].mode);
      check("vec_busy", {13'h0, bus.BUSY}, {13'h0, vecs[v].exp_busy});
      run(vecs[v].cycles - 1, vecs[v].mode);
      if (v == 3) begin
        tick(1'b1, 35'h4, 2'b00);
        run_to_pos(FRAME_LEN - 1, 2'b00);
        tick(1'b1, 35'h3, 2'b00);
        check("busy_after_wrap_load", {13'h0, bus.BUSY}, 14'h1);
        run(45, 2'b00);
      end
    end

    run_to_pos(1, 2'b00);
    tick(1'b1, 35'h7F, 2'b00);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("async_reset", {bus.COL, bus.ROW, bus.BUSY, bus.FRAME}, 14'h0);
    #0.5;
    rst_n = 1'b1;
    model_reset();
    run(50, 2'b00);

    bus.LD = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
